// File: rtl/lut_cfg_loader_if.sv
// Config-stream bus between a bitstream source (master) and lut_cfg_loader (slave).
// Carries the word handshake, control strobes and the committed LUT image.
interface lut_cfg_loader_if #(
   parameter int INPUTS   = 4,
   parameter int NUM_LUTS = 1,
   parameter int WORD_W   = 8
);
   localparam int CFG_TOT = NUM_LUTS * (2 * (2 ** INPUTS) + 1);

   logic                start;
   logic                abort;
   logic                cfg_valid;
   logic                cfg_ready;
   logic [WORD_W-1:0]   cfg_data;
   logic [CFG_TOT-1:0]  config_out;
   logic                comb_set;
   logic                busy;
   logic                done;

   modport master (
      output start, abort, cfg_valid, cfg_data,
      input  cfg_ready, config_out, comb_set, busy, done
   );

   modport slave (
      input  start, abort, cfg_valid, cfg_data,
      output cfg_ready, config_out, comb_set, busy, done
   );
endinterface

// File: rtl/lut_cfg_loader.sv
// Word-serial config loader for fracturable LUT tiles: assembles an MSB-first bitstream
// in a shadow register and publishes the full image atomically with a one-cycle comb_set.
module lut_cfg_loader #(
   parameter int INPUTS   = 4,
   parameter int NUM_LUTS = 1,
   parameter int WORD_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   lut_cfg_loader_if.slave  bus
);
   localparam int MEM_SIZE = 2 ** INPUTS;
   localparam int CFG_W    = 2 * MEM_SIZE + 1;
   localparam int TOT_W    = NUM_LUTS * CFG_W;
   localparam int NWORDS   = (TOT_W + WORD_W - 1) / WORD_W;
   localparam int PAD      = NWORDS * WORD_W - TOT_W;
   localparam int SHW      = (NWORDS - 1) * WORD_W;
   localparam int CNT_W    = $clog2(NWORDS + 1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_COMMIT
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [SHW-1:0]     r_shadow;
   logic [CNT_W-1:0]   r_cnt;
   logic [TOT_W-1:0]   r_config;
   logic               r_done;

   logic               w_beat;
   logic               w_final;
   logic [TOT_W-1:0]   w_image;

   // Only the first NWORDS-1 words live in the shadow; the final word is merged
   // on the fly, with its low PAD bits dropped.
   assign w_beat  = bus.cfg_valid && (r_state == S_LOAD);
   assign w_final = w_beat && !bus.abort && (r_cnt == LAST_IDX);
   assign w_image = {r_shadow, bus.cfg_data[WORD_W-1:PAD]};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_next = S_LOAD;
            end
         end
         S_LOAD: begin
            if (bus.abort) begin
               w_next = S_IDLE;
            end else if (w_final) begin
               w_next = S_COMMIT;
            end
         end
         S_COMMIT: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_comb begin
      bus.cfg_ready  = 1'b0;
      bus.comb_set   = 1'b0;
      bus.busy       = 1'b1;
      case (r_state)
         S_IDLE:   bus.busy      = 1'b0;
         S_LOAD:   bus.cfg_ready = 1'b1;
         S_COMMIT: bus.comb_set  = 1'b1;
         default:  bus.busy      = 1'b0;
      endcase
      bus.config_out = r_config;
      bus.done       = r_done;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_shadow <= '0;
         r_cnt    <= '0;
         r_config <= '0;
         r_done   <= 1'b0;
      end else begin
         if (r_state == S_IDLE && bus.start) begin
            r_done <= 1'b0;
         end
         if (r_state == S_COMMIT) begin
            r_done <= 1'b1;
         end
         // abort outranks a coincident beat, including the final one
         if (r_state == S_LOAD) begin
            if (bus.abort) begin
               r_shadow <= '0;
               r_cnt    <= '0;
            end else if (w_final) begin
               r_config <= w_image;
               r_shadow <= '0;
               r_cnt    <= '0;
            end else if (w_beat) begin
               r_shadow <= SHW'({r_shadow, bus.cfg_data});
               r_cnt    <= r_cnt + CNT_W'(1);
            end
         end
      end
   end
endmodule

// File: tb/tb_lut_cfg_loader.sv
// Directed bench for lut_cfg_loader: default geometry plus a 2-tile, 16-bit-word instance.
module tb_lut_cfg_loader;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_pass;
   int   strobes0;
   int   strobes1;

   localparam logic [32:0] IMG_ONE = 33'h1_0000_0001;
   localparam logic [32:0] IMG_A   = 33'h0_2468_ACF1;

   lut_cfg_loader_if #(.INPUTS(4), .NUM_LUTS(1), .WORD_W(8))  u_if0 ();
   lut_cfg_loader_if #(.INPUTS(4), .NUM_LUTS(2), .WORD_W(16)) u_if1 ();

   lut_cfg_loader #(.INPUTS(4), .NUM_LUTS(1), .WORD_W(8)) u_dut0 (
      .clk (clk),
      .rst (rst),
      .bus (u_if0)
   );

   lut_cfg_loader #(.INPUTS(4), .NUM_LUTS(2), .WORD_W(16)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (u_if1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (u_if0.comb_set === 1'b1) strobes0++;
      if (u_if1.comb_set === 1'b1) strobes1++;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic start0;
      u_if0.start = 1'b1;
      tick();
      u_if0.start = 1'b0;
   endtask

   // Word i of v is v[39-8*i -: 8]; gap idle cycles with junk data precede each beat.
   task automatic feed0(input logic [39:0] v, input int unsigned n, input int unsigned gap);
      for (int unsigned i = 0; i < n; i++) begin
         for (int unsigned g = 0; g < gap; g++) begin
            u_if0.cfg_valid = 1'b0;
            u_if0.cfg_data  = 8'hFF;
            tick();
         end
         u_if0.cfg_valid = 1'b1;
         u_if0.cfg_data  = v[39-8*i -: 8];
         tick();
      end
      u_if0.cfg_valid = 1'b0;
      u_if0.cfg_data  = 8'h00;
   endtask

   task automatic test_reset;
      n_checks++;
      if (u_if0.config_out !== 33'h0) $display("FAIL reset_config: got %h expected %h", u_if0.config_out, 33'h0);
      else n_pass++;
      n_checks++;
      if ({u_if0.comb_set, u_if0.busy, u_if0.done, u_if0.cfg_ready} !== 4'b0000)
         $display("FAIL reset_flags: got %b expected 0000", {u_if0.comb_set, u_if0.busy, u_if0.done, u_if0.cfg_ready});
      else n_pass++;
      n_checks++;
      if (u_if1.config_out !== 66'h0) $display("FAIL reset_config_wide: got %h expected %h", u_if1.config_out, 66'h0);
      else n_pass++;
   endtask

   task automatic test_single_load;
      int s;
      start0();
      n_checks++;
      if ({u_if0.busy, u_if0.cfg_ready, u_if0.done} !== 3'b110)
         $display("FAIL load_enter: got %b expected 110", {u_if0.busy, u_if0.cfg_ready, u_if0.done});
      else n_pass++;
      s = strobes0;
      feed0(40'h80_00_00_00_80, 4, 0);
      n_checks++;
      if (u_if0.config_out !== 33'h0) $display("FAIL load_no_partial: got %h expected %h", u_if0.config_out, 33'h0);
      else n_pass++;
      u_if0.cfg_valid = 1'b1;
      u_if0.cfg_data  = 8'h80;
      tick();
      u_if0.cfg_valid = 1'b0;
      n_checks++;
      if (u_if0.comb_set !== 1'b1) $display("FAIL load_strobe_latency: got %b expected 1", u_if0.comb_set);
      else n_pass++;
      n_checks++;
      if (u_if0.config_out !== IMG_ONE) $display("FAIL load_image: got %h expected %h", u_if0.config_out, IMG_ONE);
      else n_pass++;
      tick();
      n_checks++;
      if ({u_if0.comb_set, u_if0.done, u_if0.busy} !== 3'b010)
         $display("FAIL load_finish: got %b expected 010", {u_if0.comb_set, u_if0.done, u_if0.busy});
      else n_pass++;
      n_checks++;
      if (strobes0 - s !== 1) $display("FAIL load_strobe_width: got %0d expected 1", strobes0 - s);
      else n_pass++;
   endtask

   task automatic test_gapped;
      int s;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      s = strobes0;
      start0();
      feed0(40'h80_00_00_00_80, 5, 3);
      n_checks++;
      if ({u_if0.comb_set, u_if0.config_out} !== {1'b1, IMG_ONE})
         $display("FAIL gapped_commit: got %b/%h expected 1/%h", u_if0.comb_set, u_if0.config_out, IMG_ONE);
      else n_pass++;
      tick();
      n_checks++;
      if (strobes0 - s !== 1 || u_if0.done !== 1'b1)
         $display("FAIL gapped_strobe: got strobes=%0d done=%b expected 1/1", strobes0 - s, u_if0.done);
      else n_pass++;
   endtask

   task automatic test_abort;
      int s;
      start0();
      feed0(40'h12_34_56_78_9A, 5, 0);
      tick();
      n_checks++;
      if (u_if0.config_out !== IMG_A) $display("FAIL abort_image_a: got %h expected %h", u_if0.config_out, IMG_A);
      else n_pass++;
      s = strobes0;
      start0();
      feed0(40'hFF_FF_FF_00_00, 3, 0);
      u_if0.abort = 1'b1;
      tick();
      u_if0.abort = 1'b0;
      tick();
      n_checks++;
      if (u_if0.config_out !== IMG_A) $display("FAIL abort_keep: got %h expected %h", u_if0.config_out, IMG_A);
      else n_pass++;
      n_checks++;
      if ({u_if0.busy, u_if0.done, u_if0.cfg_ready, strobes0 - s} !== {3'b000, 32'd0})
         $display("FAIL abort_flags: got busy=%b done=%b ready=%b strobes=%0d expected 0/0/0/0",
                  u_if0.busy, u_if0.done, u_if0.cfg_ready, strobes0 - s);
      else n_pass++;
      // a stale counter would commit early and mangle this image
      start0();
      feed0(40'h80_00_00_00_80, 5, 0);
      n_checks++;
      if ({u_if0.comb_set, u_if0.config_out} !== {1'b1, IMG_ONE})
         $display("FAIL abort_reload: got %b/%h expected 1/%h", u_if0.comb_set, u_if0.config_out, IMG_ONE);
      else n_pass++;
      tick();
      start0();
      feed0(40'h12_34_56_78_9A, 5, 0);
      tick();
   endtask

   task automatic test_reset_midload;
      int s;
      s = strobes0;
      start0();
      feed0(40'h80_00_00_00_80, 4, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      n_checks++;
      if (u_if0.config_out !== 33'h0) $display("FAIL rstmid_config: got %h expected %h", u_if0.config_out, 33'h0);
      else n_pass++;
      n_checks++;
      if ({u_if0.busy, u_if0.done, strobes0 - s} !== {2'b00, 32'd0})
         $display("FAIL rstmid_flags: got busy=%b done=%b strobes=%0d expected 0/0/0", u_if0.busy, u_if0.done, strobes0 - s);
      else n_pass++;
      start0();
      feed0(40'h80_00_00_00_80, 5, 0);
      tick();
      n_checks++;
      if ({u_if0.done, u_if0.config_out} !== {1'b1, IMG_ONE})
         $display("FAIL rstmid_reload: got %b/%h expected 1/%h", u_if0.done, u_if0.config_out, IMG_ONE);
      else n_pass++;
   endtask

   task automatic test_abort_final_beat;
      int s;
      s = strobes0;
      start0();
      feed0(40'h12_34_56_78_9A, 4, 0);
      u_if0.cfg_valid = 1'b1;
      u_if0.cfg_data  = 8'h9A;
      u_if0.abort     = 1'b1;
      tick();
      u_if0.cfg_valid = 1'b0;
      u_if0.abort     = 1'b0;
      n_checks++;
      if ({u_if0.cfg_ready, u_if0.comb_set, u_if0.busy} !== 3'b000)
         $display("FAIL abortlast_flags: got %b expected 000", {u_if0.cfg_ready, u_if0.comb_set, u_if0.busy});
      else n_pass++;
      tick();
      n_checks++;
      if (u_if0.config_out !== IMG_ONE || strobes0 - s !== 0)
         $display("FAIL abortlast_keep: got %h strobes=%0d expected %h/0", u_if0.config_out, strobes0 - s, IMG_ONE);
      else n_pass++;
   endtask

   task automatic test_back_to_back;
      start0();
      feed0(40'h12_34_56_78_9A, 5, 0);
      u_if0.start = 1'b1;
      tick();
      u_if0.start = 1'b0;
      n_checks++;
      if ({u_if0.busy, u_if0.done, u_if0.cfg_ready} !== 3'b010)
         $display("FAIL b2b_start_ignored: got %b expected 010", {u_if0.busy, u_if0.done, u_if0.cfg_ready});
      else n_pass++;
      n_checks++;
      if (u_if0.config_out !== IMG_A) $display("FAIL b2b_image: got %h expected %h", u_if0.config_out, IMG_A);
      else n_pass++;
      u_if0.start = 1'b1;
      u_if0.abort = 1'b1;
      tick();
      u_if0.start = 1'b0;
      n_checks++;
      if ({u_if0.busy, u_if0.cfg_ready, u_if0.done} !== 3'b110)
         $display("FAIL start_abort_idle: got %b expected 110", {u_if0.busy, u_if0.cfg_ready, u_if0.done});
      else n_pass++;
      tick();
      u_if0.abort = 1'b0;
      n_checks++;
      if (u_if0.busy !== 1'b0) $display("FAIL abort_in_load: got %b expected 0", u_if0.busy);
      else n_pass++;
   endtask

   task automatic test_wide;
      int s;
      logic [79:0] v;
      v = 80'h8000_0000_0000_0000_4000;
      s = strobes1;
      u_if1.start = 1'b1;
      tick();
      u_if1.start = 1'b0;
      for (int unsigned i = 0; i < 5; i++) begin
         u_if1.cfg_valid = 1'b1;
         u_if1.cfg_data  = v[79-16*i -: 16];
         tick();
      end
      u_if1.cfg_valid = 1'b0;
      n_checks++;
      if ({u_if1.comb_set, u_if1.config_out} !== {1'b1, 66'h2_0000_0000_0000_0001})
         $display("FAIL wide_commit: got %b/%h expected 1/%h", u_if1.comb_set, u_if1.config_out, 66'h2_0000_0000_0000_0001);
      else n_pass++;
      tick();
      n_checks++;
      if (u_if1.done !== 1'b1 || strobes1 - s !== 1)
         $display("FAIL wide_finish: got done=%b strobes=%0d expected 1/1", u_if1.done, strobes1 - s);
      else n_pass++;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      strobes0 = 0;
      strobes1 = 0;
      rst = 1'b1;
      u_if0.start = 1'b0; u_if0.abort = 1'b0; u_if0.cfg_valid = 1'b0; u_if0.cfg_data = '0;
      u_if1.start = 1'b0; u_if1.abort = 1'b0; u_if1.cfg_valid = 1'b0; u_if1.cfg_data = '0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      test_reset();
      test_single_load();
      test_gapped();
      test_abort();
      test_reset_midload();
      test_abort_final_beat();
      test_back_to_back();
      test_wide();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
